scope_capture_ctrl: RTL and testbench



---
 rtl/scope_pkg.sv | 16 +
 rtl/scope_rd_skid.sv | 67 ++++++
 rtl/scope_capture_ctrl.sv | 170 +++++++++++++++++
 tb/tb_scope_capture_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and default geometry for the oscilloscope capture sequencer.
package scope_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 71;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_WAIT_TRIG,
    ST_POST_FILL,
    ST_READOUT
  } scope_state_t;

endpackage

// File: rtl/scope_rd_skid.sv
// Two-entry output buffer that absorbs the one-cycle RAM read latency.
// Entry 0 is always the head, so out_data/out_last come straight from a flop.
module scope_rd_skid #(
  parameter int DATA_WIDTH = 71
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  can_issue
);

  logic [DATA_WIDTH:0] ent0_q, ent0_d;
  logic [DATA_WIDTH:0] ent1_q, ent1_d;
  logic [1:0]          occ_q, occ_d;
  logic [1:0]          occ_after;
  logic [2:0]          committed;
  logic                pop;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent0_q[DATA_WIDTH-1:0];
  assign out_last  = ent0_q[DATA_WIDTH];
  assign pop       = out_valid && out_ready;

  // A push this cycle is the read issued last cycle, i.e. the one in flight.
  assign committed = {1'b0, occ_q} + {2'b00, push} - {2'b00, pop};
  assign can_issue = (committed < 3'd2);

  always_comb begin
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    occ_after = occ_q - {1'b0, pop};
    if (pop && (occ_q == 2'd2)) begin
      ent0_d = ent1_q;
    end
    if (push) begin
      if (occ_after == 2'd0) begin
        ent0_d = {push_last, push_data};
      end else begin
        ent1_d = {push_last, push_data};
      end
    end
    occ_d = occ_after + {1'b0, push};
    if (flush) begin
      occ_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Capture/readout sequencer: ring-buffered pre/post-trigger capture into the
// sample RAM, then oldest-first streaming of the full record.
module scope_capture_ctrl #(
  parameter int ADDR_WIDTH = scope_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = scope_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  input  logic                  trig,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  import scope_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] RD_TOTAL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] RD_FINAL = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  scope_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic                  rd_last_q, rd_last_d;
  logic                  done_q, done_d;
  logic                  wr_fire, rd_issue, can_issue, beat_fire;

  assign wr_fire  = sample_valid &&
                    (state_q inside {ST_PRE_FILL, ST_WAIT_TRIG, ST_POST_FILL});
  assign rd_issue = (state_q == ST_READOUT) && !abort &&
                    (rd_cnt_q != RD_TOTAL) && can_issue;
  assign beat_fire = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pre_len_d     = pre_len_q;
    post_cnt_d    = post_cnt_q;
    trig_addr_d   = trig_addr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_cnt_d      = rd_cnt_q;
    rd_inflight_d = rd_issue;
    rd_last_d     = rd_issue && (rd_cnt_q == RD_FINAL);
    done_d        = 1'b0;

    if (wr_fire) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ONE;
      rd_cnt_d = rd_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          pre_len_d = pre_len;
          wr_ptr_d  = '0;
          state_d   = (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
        end
      end
      ST_PRE_FILL: begin
        if (wr_fire && (wr_ptr_q == pre_len_q - ONE)) state_d = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (wr_fire && trig) begin
          trig_addr_d = wr_ptr_q;
          // DEPTH - pre_len - 1 modulo DEPTH is just the bitwise complement.
          post_cnt_d  = ~pre_len_q;
          if (pre_len_q == '1) begin
            state_d  = ST_READOUT;
            rd_ptr_d = wr_ptr_q - pre_len_q;
            rd_cnt_d = '0;
          end else begin
            state_d = ST_POST_FILL;
          end
        end
      end
      ST_POST_FILL: begin
        if (wr_fire) begin
          post_cnt_d = post_cnt_q - ONE;
          if (post_cnt_q == ONE) begin
            state_d  = ST_READOUT;
            rd_ptr_d = trig_addr_q - pre_len_q;
            rd_cnt_d = '0;
          end
        end
      end
      ST_READOUT: begin
        if (beat_fire && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops any read still in the RAM pipeline along with buffered beats.
    if (abort) begin
      state_d       = ST_IDLE;
      done_d        = 1'b0;
      rd_inflight_d = 1'b0;
      rd_last_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      pre_len_q     <= '0;
      post_cnt_q    <= '0;
      trig_addr_q   <= '0;
      rd_ptr_q      <= '0;
      rd_cnt_q      <= '0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pre_len_q     <= pre_len_d;
      post_cnt_q    <= post_cnt_d;
      trig_addr_q   <= trig_addr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      rd_last_q     <= rd_last_d;
      done_q        <= done_d;
    end
  end

  scope_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (rd_inflight_q),
    .push_data (ram_rd_data),
    .push_last (rd_last_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .can_issue (can_issue)
  );

  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = sample_data;
  assign ram_rd_addr = rd_ptr_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Randomized bench: a sample-history model predicts the captured record and
// every readout beat, write-path cycle, done pulse and abort response.
module tb_scope_capture_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 71;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic          trig = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  scope_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .pre_len      (pre_len),
    .trig         (trig),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  // External simple dual-port sample RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int idx);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    r[15:0] = idx[15:0];
    return r[DW-1:0];
  endfunction

  // One capture: arm, feed samples, drain readout. Expected record is the
  // DEPTH samples from (trigger index - pre) in the sample history since arm.
  task automatic run_capture(input string name, input int pre, input int trig_at,
                             input bit trig_pre_high, input int valid_pct,
                             input int ready_pct, input int abort_beat, input bit timed);
    logic [DW-1:0] hist[$];
    logic [DW-1:0] held_data;
    int  k, e, tk, beat, cyc, last_wr_cyc, first_v_cyc, done_cyc, abort_cyc;
    bit  fin, sv, exp_wr, hs, last_hs_prev, stall_prev, held_last;
    k = 0; e = -1; tk = -1; beat = 0; cyc = 0;
    last_wr_cyc = -1; first_v_cyc = -1; done_cyc = -1; abort_cyc = -1;
    fin = 0; last_hs_prev = 0; stall_prev = 0; held_last = 0; held_data = '0;

    @(posedge clk); #1;
    arm = 1'b1; pre_len = AW'(pre); sample_valid = 1'b0; trig = 1'b0;
    out_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("busy_at_arm", DW'(busy), DW'(0));
    @(posedge clk); #1;
    arm = 1'b0;

    while (!fin) begin
      sv = ($urandom_range(99) < valid_pct);
      sample_valid = sv;
      sample_data  = mk_data(k);
      trig = (k == trig_at) || (trig_pre_high && k < pre) || (!sv && $urandom_range(1) == 1);
      out_ready = ($urandom_range(99) < ready_pct);
      abort = (abort_cyc < 0 && abort_beat >= 0 && beat == abort_beat);
      if (abort) abort_cyc = cyc;
      @(negedge clk);

      if (cyc == 0) check("busy_after_arm", DW'(busy), DW'(1));
      exp_wr = sv && (e < 0 || k <= e);
      check("wr_en", DW'(ram_wr_en), DW'(exp_wr));
      if (exp_wr) begin
        check("wr_addr", DW'(ram_wr_addr), DW'(k % DEPTH));
        hist.push_back(sample_data);
        if (tk < 0 && trig && k >= pre) begin
          tk = k;
          e  = k + DEPTH - pre - 1;
        end
        if (k == e) last_wr_cyc = cyc;
        k++;
      end

      if (abort_cyc >= 0 && cyc > abort_cyc) begin
        if (cyc == abort_cyc + 1) begin
          check("abort_valid", DW'(out_valid), DW'(0));
          check("abort_busy", DW'(busy), DW'(0));
        end
        check("abort_no_done", DW'(done), DW'(0));
        if (cyc == abort_cyc + 4) fin = 1;
      end else begin
        if (stall_prev) begin
          check("hold_valid", DW'(out_valid), DW'(1));
          check("hold_data", out_data, held_data);
          check("hold_last", DW'(out_last), DW'(held_last));
        end
        check("done", DW'(done), DW'(last_hs_prev));
        if (last_wr_cyc < 0) check("early_valid", DW'(out_valid), DW'(0));
        if (done) begin
          done_cyc = cyc;
          check("busy_at_done", DW'(busy), DW'(0));
          fin = 1;
        end
        if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
        hs = out_valid && out_ready;
        last_hs_prev = 0;
        if (hs) begin
          if (tk >= 0 && beat < DEPTH)
            check("beat_data", out_data, hist[tk - pre + beat]);
          else
            check("beat_extra", DW'(1), DW'(0));
          check("beat_last", DW'(out_last), DW'(beat == DEPTH - 1));
          last_hs_prev = (beat == DEPTH - 1);
          beat++;
        end
        stall_prev = out_valid && !out_ready;
        held_data  = out_data;
        held_last  = out_last;
      end

      if (cyc > 20000) begin
        check("timeout", DW'(0), DW'(1));
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    abort = 1'b0; sample_valid = 1'b0; trig = 1'b0; out_ready = 1'b0;
    if (abort_beat < 0) check("beat_count", DW'(beat), DW'(DEPTH));
    if (timed) begin
      check("first_valid_lat", DW'(first_v_cyc - last_wr_cyc), DW'(3));
      check("done_lat", DW'(done_cyc - last_wr_cyc), DW'(DEPTH + 3));
    end
    $display("run %s: pre=%0d trig_idx=%0d beats=%0d cycles=%0d", name, pre, tk, beat, cyc);
  endtask

  initial begin
    sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en", DW'(ram_wr_en), DW'(0));
    check("rst_wr_addr", DW'(ram_wr_addr), DW'(0));
    check("rst_rd_addr", DW'(ram_rd_addr), DW'(0));
    check("rst_out_data", out_data, DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_last", DW'(out_last), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wr_drop", DW'(ram_wr_en), DW'(0));
    sample_valid = 1'b0;

    run_capture("pre64_trig300",   64, 300, 1'b0, 100, 100, -1, 1'b1);
    run_capture("pre0_first",       0,   0, 1'b0, 100, 100, -1, 1'b1);
    run_capture("pre255_direct",  255, 255, 1'b0, 100, 100, -1, 1'b1);
    run_capture("trig_in_prefill", 10,  40, 1'b1, 100,  60, -1, 1'b0);
    run_capture("gapped_backpr",  100, 500, 1'b0,  60,  50, -1, 1'b0);
    run_capture("abort_beat100",   30,  80, 1'b0, 100,  70, 100, 1'b0);
    run_capture("after_abort",     30,  50, 1'b0,  80,  50, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
